alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one ALU datapath (one-hot 11-bit op: add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra) between two requesters, e.g. the main execute stage and a secondary address/branch-compare unit.
- Round-robin arbitration on a valid/ready request handshake.
- Drives the internal ALU combinationally and registers its result into a single-entry response buffer tagged with the requester ID.
- Counts arbitration conflicts for performance monitoring.

Parameters:
- CNT_W, 16, width of the conflict counter; counter saturates at all-ones.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 presents an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  32  operand A (shift amount in [4:0] for shifts)
- req0_b  in  32  operand B (shifted value for shifts)
- req0_op  in  11  one-hot ALU op, same bit encoding as the ALU
- req0_ovtrap  in  1  raise ex if the op overflows (add/sub only)
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_ovtrap: same widths and meanings for requester 1
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  32  ALU result
- rsp_overflow  out  1  ALU overflow flag
- rsp_carry  out  1  ALU carry/borrow flag (carry-out XOR subtract-invert)
- rsp_zero  out  1  result == 0
- rsp_ex  out  1  overflow trap: ovtrap & overflow & (op is add or sub)
- conflict_cnt  out  CNT_W  cycles with both valid and exactly one granted

Behaviour:
- Internal ALU is combinational, instanced once, fed from the granted requester's a/b/op.
- State:
  - rr pointer (1 bit, next preferred requester)
  - response buffer (valid, id, result, 4 flags)
  - conflict counter
- Free condition: free = !rsp_valid | rsp_ready (buffer empty or draining this cycle).
- Grant:
  - If only one requester is valid, it wins.
  - If both are valid, the requester equal to rr wins.
  - reqN_ready = free & winner==N & reqN_valid.
  - At most one ready is high per cycle.
  - Ready does not depend on any reqN_ready output (no combinational loop).
- Accept (reqN_valid & reqN_ready) at edge T:
  - rsp_valid=1, rsp_id=N, result/flags/ex from the ALU at T.
  - Latency: 1 cycle.
  - Throughput: 1 op/cycle when rsp_ready is held high.
- rr update:
  - On any accept, rr <= ~winner.
  - With no accept, rr holds.
  - Guarantees each requester is granted within 2 grants while it stays valid.
- Drain without accept: rsp_valid & rsp_ready & no accept -> rsp_valid <= 0.
- Stall: rsp_valid & !rsp_ready -> all rsp_* outputs hold stable and both readys are 0.
- Request rule: requesters must hold valid and payload stable until ready. The block does not check this.
- Conflict counter: increments when req0_valid & req1_valid & free. It saturates and does not wrap.
- ex is only computed when op[add] or op[sub] is set. ovtrap is ignored for all other ops.
- Non-one-hot or all-zero op: result is undefined but the handshake is still honoured. The ALU's OR-mux yields 0 for an all-zero op, so zero=1.
- Reset (synchronous; also mid-operation):
  - rsp_valid=0, rsp_id=0, rsp_result=0, all flags=0, rr=0, conflict_cnt=0.
  - Any pending response is discarded.
  - req0_ready/req1_ready are 0 while reset is high.

Test Plan:
1. Single op: req0 add a=0x7FFFFFFF b=1 ovtrap=1, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=0x80000000, overflow=1, ex=1, zero=0.
2. Contention after reset: both valid every cycle; req0 sub 5-5, req1 sltu 1<2; rsp_ready=1 -> grants alternate 0,1,0,1. Responses: id0 result=0/zero=1/carry=0, then id1 result=1. conflict_cnt increments each cycle.
3. Back-pressure: rsp_ready=0 for 3 cycles while both valid -> both readys 0; rsp_* stable; conflict_cnt unchanged. On rsp_ready=1, the next op is accepted in the same cycle with no bubble.
4. Shift ops from req1 alone:
   - sra a=4 b=0x80000000 -> 0xF8000000.
   - srl same operands -> 0x08000000.
   - sll a=31 b=1 -> 0x80000000.
   - rr toggles to 0 after each accept.
5. Reset mid-operation: rsp_valid=1 and req1 waiting; assert reset 1 cycle -> rsp_valid=0, conflict_cnt=0, rr=0. With both valid afterwards, req0 is granted first.
6. Saturation: CNT_W=3, hold contention for 10 free cycles -> conflict_cnt stops at 7.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one ALU between two requesters with a tagged one-entry response buffer
module alu_share_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [10:0]      req0_op,
    input  logic             req0_ovtrap,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [10:0]      req1_op,
    input  logic             req1_ovtrap,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_ex,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam int ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, NOR = 5;
    localparam int SLT = 6, SLTU = 7, SLL = 8, SRL = 9, SRA = 10;

    logic             rr_q, rr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ex_q, rsp_ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        both, free, winner, accept;
    logic [31:0] a, b, bb, sra_v, result;
    logic [10:0] op;
    logic        ovtrap, inv, ovf, carry, slt;
    logic [32:0] sum;

    always_comb begin
        both       = req0_valid & req1_valid;
        free       = !rsp_valid_q | rsp_ready;
        winner     = both ? rr_q : req1_valid;
        req0_ready = !reset & free & !winner & req0_valid;
        req1_ready = !reset & free & winner & req1_valid;
        accept     = req0_ready | req1_ready;
        a          = winner ? req1_a : req0_a;
        b          = winner ? req1_b : req0_b;
        op         = winner ? req1_op : req0_op;
        ovtrap     = winner ? req1_ovtrap : req0_ovtrap;
        // compares reuse the subtractor; carry reports borrow when subtracting
        inv        = op[SUB] | op[SLT] | op[SLTU];
        bb         = inv ? ~b : b;
        sum        = {1'b0, a} + {1'b0, bb} + {32'b0, inv};
        ovf        = (a[31] == bb[31]) & (sum[31] != a[31]);
        carry      = sum[32] ^ inv;
        slt        = sum[31] ^ ovf;
        sra_v      = 32'($signed(b) >>> a[4:0]);
        result     = ({32{op[ADD] | op[SUB]}} & sum[31:0])
                   | ({32{op[AND]}} & (a & b))
                   | ({32{op[OR]}} & (a | b))
                   | ({32{op[XOR]}} & (a ^ b))
                   | ({32{op[NOR]}} & ~(a | b))
                   | ({32{op[SLT]}} & {31'b0, slt})
                   | ({32{op[SLTU]}} & {31'b0, carry})
                   | ({32{op[SLL]}} & (b << a[4:0]))
                   | ({32{op[SRL]}} & (b >> a[4:0]))
                   | ({32{op[SRA]}} & sra_v);
        rsp_valid_d    = accept ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_id_d       = accept ? winner : rsp_id_q;
        rsp_result_d   = accept ? result : rsp_result_q;
        rsp_overflow_d = accept ? ovf : rsp_overflow_q;
        rsp_carry_d    = accept ? carry : rsp_carry_q;
        rsp_zero_d     = accept ? (result == 32'b0) : rsp_zero_q;
        rsp_ex_d       = accept ? (ovtrap & ovf & (op[ADD] | op[SUB])) : rsp_ex_q;
        rr_d           = accept ? ~winner : rr_q;
        cnt_d          = (both & free & ~&cnt_q) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q           <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= 32'b0;
            rsp_overflow_q <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_ex_q       <= 1'b0;
            cnt_q          <= '0;
        end else begin
            rr_q           <= rr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_ex_q       <= rsp_ex_d;
            cnt_q          <= cnt_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_ex       = rsp_ex_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vector table plus handshake/arbitration sequences
module tb_alu_share_arb;
    localparam logic [10:0] ADD = 11'h001, SUB = 11'h002, AND = 11'h004, OR = 11'h008;
    localparam logic [10:0] XOR = 11'h010, NOR = 11'h020, SLT = 11'h040, SLTU = 11'h080;
    localparam logic [10:0] SLL = 11'h100, SRL = 11'h200, SRA = 11'h400;

    logic        clk = 0, reset = 1;
    logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [10:0] req0_op = 0, req1_op = 0;
    logic        req0_ovtrap = 0, req1_ovtrap = 0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_carry, rsp_zero, rsp_ex;
    logic [15:0] conflict_cnt;
    logic        s0_ready, s1_ready, s_valid, s_id, s_ov, s_cy, s_z, s_ex;
    logic [31:0] s_result;
    logic [2:0]  s_cnt;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_ovtrap(req0_ovtrap),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_ovtrap(req1_ovtrap),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ex(rsp_ex),
        .conflict_cnt(conflict_cnt)
    );

    alu_share_arb #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(s0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_ovtrap(req0_ovtrap),
        .req1_valid(req1_valid), .req1_ready(s1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_ovtrap(req1_ovtrap),
        .rsp_valid(s_valid), .rsp_ready(rsp_ready), .rsp_id(s_id), .rsp_result(s_result),
        .rsp_overflow(s_ov), .rsp_carry(s_cy), .rsp_zero(s_z), .rsp_ex(s_ex),
        .conflict_cnt(s_cnt)
    );

    typedef struct {
        logic        rid;
        logic [31:0] a, b;
        logic [10:0] op;
        logic        ovt;
        logic [31:0] res;
        logic        ov, cy, z, ex, fl;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [10:0] op, input logic ovt);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_ovtrap = ovt;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [10:0] op, input logic ovt);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_ovtrap = ovt;
    endtask

    task automatic chk_rdy(input string nm, input logic r0, input logic r1);
        chk({nm, "_rdy0"}, {31'b0, req0_ready}, {31'b0, r0});
        chk({nm, "_rdy1"}, {31'b0, req1_ready}, {31'b0, r1});
    endtask

    task automatic chk_rsp(input string nm, input logic v, input logic id, input logic [31:0] res);
        chk({nm, "_valid"}, {31'b0, rsp_valid}, {31'b0, v});
        chk({nm, "_id"}, {31'b0, rsp_id}, {31'b0, id});
        chk({nm, "_result"}, rsp_result, res);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rid a             b             op    ovt res           ov cy z  ex fl
        tv[0]  = '{0, 32'h7FFFFFFF, 32'h00000001, ADD,  1, 32'h80000000, 1, 0, 0, 1, 1};
        tv[1]  = '{0, 32'h00000005, 32'h00000005, SUB,  1, 32'h00000000, 0, 0, 1, 0, 1};
        tv[2]  = '{1, 32'h00000001, 32'h00000002, SLTU, 1, 32'h00000001, 0, 1, 0, 0, 1};
        tv[3]  = '{1, 32'h00000004, 32'h80000000, SRA,  0, 32'hF8000000, 0, 0, 0, 0, 0};
        tv[4]  = '{1, 32'h00000004, 32'h80000000, SRL,  0, 32'h08000000, 0, 0, 0, 0, 0};
        tv[5]  = '{1, 32'h0000001F, 32'h00000001, SLL,  0, 32'h80000000, 0, 0, 0, 0, 0};
        tv[6]  = '{0, 32'hF0F0F0F0, 32'h0FF00FF0, AND,  1, 32'h00F000F0, 0, 0, 0, 0, 0};
        tv[7]  = '{0, 32'hF0000000, 32'h0000000F, OR,   0, 32'hF000000F, 0, 0, 0, 0, 0};
        tv[8]  = '{0, 32'hFFFF0000, 32'hFF00FF00, XOR,  0, 32'h00FFFF00, 0, 0, 0, 0, 0};
        tv[9]  = '{0, 32'h00000000, 32'h00000000, NOR,  0, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
        tv[10] = '{1, 32'hFFFFFFFF, 32'h00000001, SLT,  0, 32'h00000001, 0, 0, 0, 0, 0};
        tv[11] = '{1, 32'hFFFFFFFF, 32'h00000001, SLTU, 0, 32'h00000000, 0, 0, 1, 0, 1};
        tv[12] = '{0, 32'h80000000, 32'h00000001, SUB,  1, 32'h7FFFFFFF, 1, 0, 0, 1, 1};
        tv[13] = '{0, 32'hFFFFFFFF, 32'h00000001, ADD,  1, 32'h00000000, 0, 1, 1, 0, 1};
        tv[14] = '{1, 32'h7FFFFFFF, 32'h00000001, ADD,  0, 32'h80000000, 1, 0, 0, 0, 1};
        tv[15] = '{0, 32'h12345678, 32'h0000FFFF, 11'h0, 1, 32'h00000000, 0, 0, 1, 0, 0};

        // reset state, readys held low while reset is high
        @(negedge clk);
        set0(1, 1, 2, ADD, 0);
        set1(1, 1, 2, ADD, 0);
        #1 chk_rdy("reset", 0, 0);
        tick();
        chk_rsp("reset", 0, 0, 0);
        chk("reset_flags", {28'b0, rsp_overflow, rsp_carry, rsp_zero, rsp_ex}, 0);
        chk("reset_cnt", {16'b0, conflict_cnt}, 0);
        @(negedge clk);
        reset = 0;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);

        // table: one requester at a time, back-to-back with rsp_ready high
        for (int i = 0; i < 16; i++) begin
            if (tv[i].rid) set1(1, tv[i].a, tv[i].b, tv[i].op, tv[i].ovt);
            else set0(1, tv[i].a, tv[i].b, tv[i].op, tv[i].ovt);
            #1 chk_rdy($sformatf("v%0d", i), !tv[i].rid, tv[i].rid);
            tick();
            chk_rsp($sformatf("v%0d", i), 1, tv[i].rid, tv[i].res);
            chk($sformatf("v%0d_zero", i), {31'b0, rsp_zero}, {31'b0, tv[i].z});
            chk($sformatf("v%0d_ex", i), {31'b0, rsp_ex}, {31'b0, tv[i].ex});
            if (tv[i].fl) begin
                chk($sformatf("v%0d_ovf", i), {31'b0, rsp_overflow}, {31'b0, tv[i].ov});
                chk($sformatf("v%0d_carry", i), {31'b0, rsp_carry}, {31'b0, tv[i].cy});
            end
            @(negedge clk);
            set0(0, 0, 0, 0, 0);
            set1(0, 0, 0, 0, 0);
        end
        chk("table_cnt", {16'b0, conflict_cnt}, 0);

        // contention after reset: grants alternate 0,1,0,1
        reset = 1;
        tick();
        @(negedge clk);
        reset = 0;
        set0(1, 5, 5, SUB, 0);
        set1(1, 1, 2, SLTU, 0);
        for (int k = 0; k < 4; k++) begin
            #1 chk_rdy($sformatf("cont%0d", k), k % 2 == 0, k % 2 == 1);
            tick();
            chk_rsp($sformatf("cont%0d", k), 1, k % 2 == 1, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_zero", k), {31'b0, rsp_zero}, (k % 2 == 1) ? 32'd0 : 32'd1);
            chk($sformatf("cont%0d_carry", k), {31'b0, rsp_carry}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_cnt", k), {16'b0, conflict_cnt}, k + 1);
            @(negedge clk);
        end

        // back-pressure: response frozen, no grants, counter frozen
        rsp_ready = 0;
        for (int j = 0; j < 3; j++) begin
            #1 chk_rdy($sformatf("stall%0d", j), 0, 0);
            tick();
            chk_rsp($sformatf("stall%0d", j), 1, 1, 1);
            chk($sformatf("stall%0d_cnt", j), {16'b0, conflict_cnt}, 4);
            @(negedge clk);
        end
        rsp_ready = 1;
        #1 chk_rdy("unstall", 1, 0);
        tick();
        chk_rsp("unstall", 1, 0, 0);
        chk("unstall_cnt", {16'b0, conflict_cnt}, 5);

        // back-to-back shifts from req1 alone, then rr must favour req0
        @(negedge clk);
        set0(0, 5, 5, SUB, 0);
        set1(1, 4, 32'h80000000, SRA, 0);
        #1 chk_rdy("sra", 0, 1);
        tick();
        chk_rsp("sra", 1, 1, 32'hF8000000);
        @(negedge clk);
        set1(1, 4, 32'h80000000, SRL, 0);
        #1 chk_rdy("srl", 0, 1);
        tick();
        chk_rsp("srl", 1, 1, 32'h08000000);
        @(negedge clk);
        set1(1, 31, 1, SLL, 0);
        #1 chk_rdy("sll", 0, 1);
        tick();
        chk_rsp("sll", 1, 1, 32'h80000000);
        @(negedge clk);
        req0_valid = 1;
        #1 chk_rdy("rr_after_shift", 1, 0);
        tick();
        chk_rsp("rr_after_shift", 1, 0, 0);
        @(negedge clk);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();
        chk("drain_valid", {31'b0, rsp_valid}, 0);

        // reset mid-operation discards the response and restores rr=0
        @(negedge clk);
        set0(1, 5, 5, SUB, 0);
        tick();
        @(negedge clk);
        req0_valid = 0;
        set1(1, 31, 1, SLL, 0);
        rsp_ready = 0;
        #1 chk_rdy("wait1", 0, 0);
        tick();
        @(negedge clk);
        reset = 1;
        req0_valid = 1;
        #1 chk_rdy("midreset", 0, 0);
        tick();
        chk_rsp("midreset", 0, 0, 0);
        chk("midreset_cnt", {16'b0, conflict_cnt}, 0);
        @(negedge clk);
        reset = 0;
        rsp_ready = 1;
        #1 chk_rdy("post_reset", 1, 0);
        tick();
        chk_rsp("post_reset", 1, 0, 0);
        chk("post_reset_cnt", {16'b0, conflict_cnt}, 1);

        // saturation on the 3-bit counter instance
        @(negedge clk);
        reset = 1;
        tick();
        @(negedge clk);
        reset = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 7) chk("sat_at7", {29'b0, s_cnt}, 7);
            @(negedge clk);
        end
        chk("sat_cnt", {29'b0, s_cnt}, 7);
        chk("wide_cnt", {16'b0, conflict_cnt}, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
